// File: rtl/i2s_rx_fifo.sv
// I2S receiver for the WM8731 ADC path: oversampled BCLK/LRC/DATA deserialiser,
// optional mono/channel select, and a valid/ready FIFO toward the FFT front end.
module i2s_rx_fifo #(
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned FRAME_BITS   = 64,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned MODE         = 0
) (
  input  logic                              MCLK,
  input  logic                              reset,
  input  logic                              AUD_BCLK,
  input  logic                              AUD_LRC,
  input  logic                              AUD_ADC_DATA,
  input  logic                              out_ready,
  output logic                              out_valid,
  output logic [SAMPLE_WIDTH-1:0]           out_left,
  output logic [SAMPLE_WIDTH-1:0]           out_right,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              overflow,
  output logic                              frame_err,
  output logic                              LRC_OUT
);

  localparam int unsigned SW = SAMPLE_WIDTH;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CW = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {SYNC, DELAY, SHIFT, PAD} state_t;

  logic bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic lrc_s1_q, lrc_s2_q, dat_s1_q, dat_s2_q;

  always_ff @(posedge MCLK) begin
    if (reset) begin
      {bclk_s1_q, bclk_s2_q, bclk_s3_q} <= '0;
      {lrc_s1_q, lrc_s2_q}               <= '0;
      {dat_s1_q, dat_s2_q}               <= '0;
    end else begin
      {bclk_s3_q, bclk_s2_q, bclk_s1_q} <= {bclk_s2_q, bclk_s1_q, AUD_BCLK};
      {lrc_s2_q, lrc_s1_q}               <= {lrc_s1_q, AUD_LRC};
      {dat_s2_q, dat_s1_q}               <= {dat_s1_q, AUD_ADC_DATA};
    end
  end

  logic          bclk_rise, lrc_edge, last_bit, push;
  logic          lrc_prev_q, chan_q, lvalid_q, frame_err_q;
  state_t        state_q;
  logic [CW-1:0] bitcnt_q;
  logic [SW-1:0] sh_q, left_q, shifted;

  assign bclk_rise = bclk_s2_q & ~bclk_s3_q;
  assign lrc_edge  = lrc_s2_q != lrc_prev_q;
  assign shifted   = {sh_q[SW-2:0], dat_s2_q};
  assign last_bit  = bitcnt_q == CW'(SW - 1);
  assign push      = bclk_rise && (state_q == SHIFT) && !lrc_edge && last_bit && chan_q && lvalid_q;

  // The BCLK rise that reveals the LRC edge carries the delay-slot bit itself,
  // so DELAY only lasts one MCLK and the next BCLK rise shifts the MSB.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_q     <= SYNC;
      lrc_prev_q  <= 1'b0;
      chan_q      <= 1'b0;
      lvalid_q    <= 1'b0;
      frame_err_q <= 1'b0;
      bitcnt_q    <= '0;
      sh_q        <= '0;
      left_q      <= '0;
    end else begin
      if (bclk_rise) lrc_prev_q <= lrc_s2_q;
      unique case (state_q)
        SYNC: if (bclk_rise && lrc_edge && !lrc_s2_q) begin
          chan_q  <= 1'b0;
          state_q <= DELAY;
        end
        DELAY: begin
          bitcnt_q <= '0;
          state_q  <= SHIFT;
        end
        SHIFT: if (bclk_rise) begin
          if (lrc_edge) begin
            frame_err_q <= 1'b1;
            lvalid_q    <= 1'b0;
            chan_q      <= lrc_s2_q;
            state_q     <= DELAY;
          end else begin
            sh_q     <= shifted;
            bitcnt_q <= bitcnt_q + CW'(1);
            if (last_bit) begin
              state_q <= PAD;
              if (!chan_q) begin
                left_q   <= shifted;
                lvalid_q <= 1'b1;
              end else begin
                lvalid_q <= 1'b0;
              end
            end
          end
        end
        PAD: if (bclk_rise && lrc_edge) begin
          chan_q  <= lrc_s2_q;
          state_q <= DELAY;
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  logic [SW:0]     sum;
  logic [SW-1:0]   avg;
  logic [2*SW-1:0] push_word;

  assign sum = {left_q[SW-1], left_q} + {shifted[SW-1], shifted};
  assign avg = SW'(sum >> 1);

  always_comb begin
    push_word = {left_q, shifted};
    case (MODE)
      1:       push_word = {avg, avg};
      2:       push_word = {left_q, left_q};
      3:       push_word = {shifted, shifted};
      default: push_word = {left_q, shifted};
    endcase
  end

  logic [2*SW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_q, rd_q, rd_d;
  logic [LW-1:0]   level_q, level_d;
  logic [SW-1:0]   head_l_q, head_r_q;
  logic            overflow_q, full, pop, wr_en;

  assign full    = level_q == LW'(FIFO_DEPTH);
  assign pop     = out_valid && out_ready;
  assign wr_en   = push && (!full || pop);
  assign rd_d    = pop ? rd_q + PW'(1) : rd_q;
  assign level_d = level_q + LW'(wr_en) - LW'(pop);

  always_ff @(posedge MCLK) begin
    if (wr_en) mem_q[wr_q] <= push_word;
  end

  // Head register reloads from the next read slot, bypassing a same-cycle write into it.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      head_l_q   <= '0;
      head_r_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      level_q <= level_d;
      if (wr_en) wr_q <= wr_q + PW'(1);
      if (push && full && !pop) overflow_q <= 1'b1;
      if (level_d != '0) begin
        if (wr_en && (wr_q == rd_d)) {head_l_q, head_r_q} <= push_word;
        else                         {head_l_q, head_r_q} <= mem_q[rd_d];
      end
    end
  end

  assign out_valid  = level_q != '0;
  assign out_left   = head_l_q;
  assign out_right  = head_r_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;
  assign LRC_OUT    = lrc_s2_q;

endmodule

// File: tb/tb_i2s_rx_fifo.sv
// Randomised bench for i2s_rx_fifo: four instances (MODE 0..3) share one I2S stream
// and are checked against a frame-level queue model of the FIFO.
module tb_i2s_rx_fifo;

  localparam int SW    = 24;
  localparam int DEPTH = 16;
  localparam int HALF  = 32;
  localparam int LW    = $clog2(DEPTH + 1);

  logic MCLK = 1'b0, reset = 1'b1;
  logic AUD_BCLK = 1'b0, AUD_LRC = 1'b1, AUD_ADC_DATA = 1'b0, out_ready = 1'b0;

  logic          ov  [4];
  logic [SW-1:0] ol  [4];
  logic [SW-1:0] orr [4];
  logic [LW-1:0] lvl [4];
  logic          ovf [4];
  logic          fe  [4];
  logic          lo  [4];

  int unsigned     n_checks = 0, n_err = 0;
  logic [2*SW-1:0] mq[$];
  logic            model_ovf = 1'b0;
  logic [SW-1:0]   cur_l, cur_r;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    i2s_rx_fifo #(.SAMPLE_WIDTH(SW), .FRAME_BITS(64), .FIFO_DEPTH(DEPTH), .MODE(m)) dut (
      .MCLK(MCLK), .reset(reset), .AUD_BCLK(AUD_BCLK), .AUD_LRC(AUD_LRC),
      .AUD_ADC_DATA(AUD_ADC_DATA), .out_ready(out_ready), .out_valid(ov[m]),
      .out_left(ol[m]), .out_right(orr[m]), .fifo_level(lvl[m]), .overflow(ovf[m]),
      .frame_err(fe[m]), .LRC_OUT(lo[m])
    );
  end

  always #10 MCLK = ~MCLK;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] mono(input logic [SW-1:0] l, input logic [SW-1:0] r);
    int sl, sr, a;
    sl = int'(l) - (l[SW-1] ? (1 << SW) : 0);
    sr = int'(r) - (r[SW-1] ? (1 << SW) : 0);
    a  = (sl + sr) >>> 1;
    return a[SW-1:0];
  endfunction

  function automatic logic [SW-1:0] exp_l(input int m, input logic [SW-1:0] l, input logic [SW-1:0] r);
    case (m)
      1:       return mono(l, r);
      3:       return r;
      default: return l;
    endcase
  endfunction

  function automatic logic [SW-1:0] exp_r(input int m, input logic [SW-1:0] l, input logic [SW-1:0] r);
    case (m)
      1:       return mono(l, r);
      2:       return l;
      default: return r;
    endcase
  endfunction

  task automatic check_head(input string tag, input logic [2*SW-1:0] e);
    logic [SW-1:0] l, r;
    l = e[2*SW-1:SW];
    r = e[SW-1:0];
    for (int m = 0; m < 4; m++) begin
      check($sformatf("%s_valid_m%0d", tag, m), ov[m], 1);
      check($sformatf("%s_left_m%0d", tag, m), ol[m], exp_l(m, l, r));
      check($sformatf("%s_right_m%0d", tag, m), orr[m], exp_r(m, l, r));
    end
  endtask

  task automatic check_all(input string tag, input int level, input logic o, input logic f);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("%s_level_m%0d", tag, m), lvl[m], level);
      check($sformatf("%s_valid_m%0d", tag, m), ov[m], level != 0);
      check($sformatf("%s_overflow_m%0d", tag, m), ovf[m], o);
      check($sformatf("%s_frame_err_m%0d", tag, m), fe[m], f);
    end
  endtask

  task automatic model_push(input logic [SW-1:0] l, input logic [SW-1:0] r);
    if (mq.size() < DEPTH) mq.push_back({l, r});
    else model_ovf = 1'b1;
  endtask

  // kind 1: push-latency check with out_ready held high; kind 2: pop in the push cycle
  task automatic send_bit(input logic lrc, input logic d, input int kind);
    AUD_LRC      = lrc;
    AUD_ADC_DATA = d;
    AUD_BCLK     = 1'b0;
    repeat (4) @(negedge MCLK);
    AUD_BCLK = 1'b1;
    if (kind == 1) begin
      @(posedge MCLK); @(posedge MCLK); #1;
      for (int m = 0; m < 4; m++) check($sformatf("lat_pre_m%0d", m), ov[m], 0);
      @(posedge MCLK); #1;
      check_head("lat_post", {cur_l, cur_r});
    end else if (kind == 2) begin
      @(posedge MCLK); @(posedge MCLK); @(negedge MCLK);
      check_head("fullpop_head", mq[0]);
      out_ready = 1'b1;
      @(negedge MCLK);
      out_ready = 1'b0;
      void'(mq.pop_front());
      mq.push_back({cur_l, cur_r});
    end
    repeat (4) @(negedge MCLK);
  endtask

  task automatic send_half(input logic lrc, input logic [SW-1:0] val, input int ndata,
                           input int total, input int kind);
    for (int i = 0; i < total; i++) begin
      logic d;
      int   k;
      d = 1'($urandom_range(0, 1));
      k = 0;
      if (i >= 1 && i <= ndata) d = val[SW-i];
      if (i == ndata && ndata == SW) k = kind;
      send_bit(lrc, d, k);
    end
  endtask

  task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r,
                            input int rcut, input int kind);
    cur_l = l;
    cur_r = r;
    send_half(1'b0, l, SW, HALF, 0);
    if (rcut != 0) send_half(1'b1, r, rcut, rcut + 1, 0);
    else           send_half(1'b1, r, SW, HALF, kind);
  endtask

  task automatic preamble();
    repeat (3) send_bit(1'b1, 1'($urandom_range(0, 1)), 0);
  endtask

  task automatic do_reset();
    @(negedge MCLK) reset = 1'b1;
    @(negedge MCLK) reset = 1'b0;
    mq.delete();
    model_ovf = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (mq.size() > 0) begin
      check_head(tag, mq[0]);
      out_ready = 1'b1;
      @(negedge MCLK);
      out_ready = 1'b0;
      void'(mq.pop_front());
    end
    for (int m = 0; m < 4; m++) begin
      check($sformatf("%s_empty_valid_m%0d", tag, m), ov[m], 0);
      check($sformatf("%s_empty_level_m%0d", tag, m), lvl[m], 0);
    end
  endtask

  function automatic logic [SW-1:0] rnd();
    return SW'($urandom);
  endfunction

  initial begin
    logic [SW-1:0] l, r;

    repeat (3) @(negedge MCLK);
    check_all("reset", 0, 1'b0, 1'b0);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("reset_left_m%0d", m), ol[m], 0);
      check($sformatf("reset_right_m%0d", m), orr[m], 0);
      check($sformatf("reset_lrc_m%0d", m), lo[m], 0);
    end
    reset = 1'b0;

    // Stereo frame drained as it arrives, with push latency observed
    out_ready = 1'b1;
    preamble();
    check("lrc_out_high", lo[0], 1);
    send_frame(24'h123456, 24'hABCDEF, 0, 1);
    check_all("single", 0, 1'b0, 1'b0);
    out_ready = 1'b0;

    // Mono corner cases plus random frames
    send_frame(24'h7FFFFF, 24'h7FFFFF, 0, 0); model_push(24'h7FFFFF, 24'h7FFFFF);
    send_frame(24'h800000, 24'h000002, 0, 0); model_push(24'h800000, 24'h000002);
    send_frame(24'hFFFFFF, 24'h000000, 0, 0); model_push(24'hFFFFFF, 24'h000000);
    repeat (3) begin
      l = rnd(); r = rnd();
      send_frame(l, r, 0, 0); model_push(l, r);
    end
    check_all("mono", mq.size(), 1'b0, 1'b0);
    drain("mono");

    // Full FIFO with a pop coinciding with the push
    do_reset();
    preamble();
    repeat (DEPTH) begin
      l = rnd(); r = rnd();
      send_frame(l, r, 0, 0); model_push(l, r);
    end
    check_all("full", DEPTH, 1'b0, 1'b0);
    send_frame(rnd(), rnd(), 0, 2);
    check_all("fullpop", DEPTH, 1'b0, 1'b0);
    drain("fullpop");

    // Overflow: two frames beyond capacity are dropped
    do_reset();
    preamble();
    repeat (DEPTH + 2) begin
      l = rnd(); r = rnd();
      send_frame(l, r, 0, 0); model_push(l, r);
    end
    check_all("ovf", DEPTH, model_ovf, 1'b0);
    drain("ovf");

    // Right channel cut short, then a clean frame
    send_frame(rnd(), rnd(), 10, 0);
    l = rnd(); r = rnd();
    send_frame(l, r, 0, 0); model_push(l, r);
    check_all("cut", 1, 1'b1, 1'b1);
    drain("cut");

    // Reset at bit 12 of a left channel
    l = rnd();
    send_bit(1'b0, 1'($urandom_range(0, 1)), 0);
    for (int i = 1; i <= 12; i++) send_bit(1'b0, l[SW-i], 0);
    do_reset();
    check_all("midrst", 0, 1'b0, 1'b0);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("midrst_left_m%0d", m), ol[m], 0);
      check($sformatf("midrst_right_m%0d", m), orr[m], 0);
      check($sformatf("midrst_lrc_m%0d", m), lo[m], 0);
    end
    for (int i = 13; i < HALF; i++) send_bit(1'b0, (i <= SW) ? l[SW-i] : 1'b0, 0);
    send_half(1'b1, rnd(), SW, HALF, 0);
    l = rnd(); r = rnd();
    send_frame(l, r, 0, 0); model_push(l, r);
    check_all("midrst_after", 1, 1'b0, 1'b0);
    drain("midrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
